// File: rtl/shift_mult_pkg.sv
// Shared constants and types for the sequential radix-2 Booth multiplier.
package shift_mult_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/booth_shift_core.sv
// Iterative radix-2 Booth core: one add/sub plus arithmetic right shift per clock.
module booth_shift_core
    import shift_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     m_held,
    output logic [WIDTH-1:0]     q_held,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [2*WIDTH+1:0] p_reg;
    logic [CW-1:0]      cnt;
    logic               busy;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     acc_next;
    logic [2*WIDTH+1:0] p_next;

    // Accumulator is one bit wider than M so that subtracting -2^(WIDTH-1) cannot overflow.
    assign m_ext = {m_reg[WIDTH-1], m_reg};
    assign acc   = p_reg[2*WIDTH+1:WIDTH+1];

    always_comb begin
        acc_next = acc;
        case (p_reg[1:0])
            2'b01:   acc_next = acc + m_ext;
            2'b10:   acc_next = acc - m_ext;
            default: acc_next = acc;
        endcase
        p_next = {acc_next[WIDTH], acc_next, p_reg[WIDTH:1]};
    end

    assign done    = busy && (cnt == CW'(WIDTH - 1));
    assign product = p_reg[2*WIDTH:1];
    assign m_held  = m_reg;
    assign q_held  = q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            q_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            p_reg <= {{(WIDTH+1){1'b0}}, multiplier, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            p_reg <= p_next;
            cnt   <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_integration.sv
// Free-running signed multiplier wrapper: recomputes on operand change, holds product in output1.
module shift_integration
    import shift_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     input1,
    input  logic [WIDTH-1:0]     input2,
    output logic [2*WIDTH-1:0]   output1
);

    state_t             state;
    logic               start;
    logic               changed;
    logic               done;
    logic [WIDTH-1:0]   m_held;
    logic [WIDTH-1:0]   q_held;
    logic [2*WIDTH-1:0] product;

    assign start   = (state == LOAD);
    assign changed = (input1 != m_held) || (input2 != q_held);

    booth_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (input1),
        .multiplier   (input2),
        .m_held       (m_held),
        .q_held       (q_held),
        .done         (done),
        .product      (product)
    );

    // A change during RUN or DONE abandons the run; output1 only updates from a clean DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            output1 <= '0;
        end else begin
            case (state)
                LOAD: state <= RUN;
                RUN: begin
                    if (changed) begin
                        state <= LOAD;
                    end else if (done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (changed) begin
                        state <= LOAD;
                    end else begin
                        output1 <= product;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_integration.sv
// Directed bench for shift_integration: product table, mid-run change, async reset, stability.
module tb_shift_integration;
    import shift_mult_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expect_p;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] input1 = '0;
    logic [31:0] input2 = '0;
    logic [63:0] output1;

    int vectors = 0;
    int miscompares = 0;

    vec_t vecs[10];

    shift_integration #(
        .WIDTH (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .input1  (input1),
        .input2  (input2),
        .output1 (output1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_not_load(input string name);
        vectors++;
        if (dut.state === LOAD) begin
            miscompares++;
            $display("FAIL %s: state is LOAD, expected not LOAD", name);
        end
    endtask

    task automatic wait_for(input string name, input logic [63:0] exp, input int unsigned budget);
        bit hit = 1'b0;
        for (int unsigned i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (output1 === exp) hit = 1'b1;
        end
        check(name, output1, exp);
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        input1 = a;
        input2 = b;
    endtask

    initial begin
        bit          seen;
        logic [63:0] got;

        vecs[0] = '{32'h0000_0005, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFE7, "5x-5"};
        vecs[1] = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 64'h0000_0000_0000_0019, "-5x-5"};
        vecs[2] = '{32'hFFFF_FFFB, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFE7, "-5x5"};
        vecs[3] = '{32'hFFFF_FFF4, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFB8, "-12x6"};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFB, 64'h0000_0000_0000_0000, "0x-5"};
        vecs[5] = '{32'h0000_0001, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, "1x-5"};
        vecs[6] = '{32'h0000_0008, 32'h0000_0006, 64'h0000_0000_0000_0030, "8x6"};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min"};
        vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "max_x_min"};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "-1x-1"};

        // Reset state, then first computation after release.
        input1 = 32'd5;
        input2 = 32'd5;
        repeat (3) @(negedge clk);
        check("reset_output", output1, 64'd0);
        vectors++;
        if (dut.state !== LOAD) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, LOAD);
        end
        rst_n = 1'b1;
        wait_for("release_5x5", 64'd25, 36);

        // Product table: each pattern settles within 36 cycles and holds to 50.
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].a, vecs[i].b);
            wait_for(vecs[i].name, vecs[i].expect_p, 36);
            repeat (14) @(negedge clk);
            check({vecs[i].name, "_hold"}, output1, vecs[i].expect_p);
        end

        // Mid-run change: 3x3 abandoned after 10 cycles in favour of 7x-2.
        apply(32'd5, 32'd5);
        wait_for("pre_midrun", 64'd25, 36);
        apply(32'd3, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrun_before_change", output1, 64'd25);
        end
        input1 = 32'd7;
        input2 = 32'hFFFF_FFFE;
        seen = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            got = output1;
            if (got === 64'hFFFF_FFFF_FFFF_FFF2) seen = 1'b1;
            vectors++;
            if (!((got === 64'd25 && !seen) || got === 64'hFFFF_FFFF_FFFF_FFF2)) begin
                miscompares++;
                $display("FAIL midrun_glitch: got %h expected 0000000000000019 or fffffffffffffff2", got);
            end
        end
        check("midrun_result", output1, 64'hFFFF_FFFF_FFFF_FFF2);

        // Asynchronous reset asserted mid-computation clears output1 at once.
        apply(32'h0001_2345, 32'h0000_0678);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_output", output1, 64'd0);
        vectors++;
        if (dut.state !== LOAD) begin
            miscompares++;
            $display("FAIL async_reset_state: got %0d expected %0d", dut.state, LOAD);
        end
        @(negedge clk);
        input1 = 32'd5;
        input2 = 32'd5;
        @(negedge clk);
        rst_n = 1'b1;
        wait_for("rerelease_5x5", 64'd25, 36);

        // Stability: stable operands never trigger recomputation.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("stable_5x5", output1, 64'd25);
            check_not_load("stable_no_load");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_integration.md
Name: shift_integration

Overview:
- Sequential signed 32x32 multiplier: radix-2 Booth, shift-and-add, one Booth step per clock.
- Free-running, with no start or valid handshake.
- Watches its operand inputs, recomputes automatically whenever they change, and holds the 64-bit two's-complement product on a registered output.
- Sits as the integration wrapper around the iterative multiplier core in the datapath.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- input1  input  WIDTH  multiplicand, signed two's complement
- input2  input  WIDTH  multiplier, signed two's complement
- output1  output  2*WIDTH  registered signed product input1*input2

Behaviour:
- Reset (rst_n=0, asynchronous):
  - output1=0, state=LOAD, step counter=0, internal registers=0.
  - On release, the first computation starts at the next clk edge.
- States: LOAD, RUN, DONE, HOLD.
- LOAD (1 cycle):
  - Capture input1 into M_reg and input2 into Q_reg.
  - Initialise the product register P = {(WIDTH+1)'b0, input2, 1'b0}, a 2*WIDTH+2 bit register.
  - Clear the counter, then go to RUN.
- RUN (WIDTH cycles):
  - Examine P[1:0]. 01 -> upper WIDTH+1 bits += sign-extended M_reg. 10 -> upper bits -= sign-extended M_reg. 00/11 -> no change.
  - Then arithmetic right-shift P by 1 and increment the counter.
  - The upper accumulator is WIDTH+1 bits so that M = -2^(WIDTH-1) cannot overflow.
  - After the WIDTH-th step, go to DONE.
- DONE (1 cycle): output1 <= P[2*WIDTH:1], then go to HOLD.
- HOLD: each cycle compare input1/input2 with M_reg/Q_reg. On any difference go to LOAD; otherwise stay in HOLD.
- Latency:
  - An input change is seen in HOLD at edge N. LOAD occurs at N+1, RUN at N+2..N+WIDTH+1, and output1 updates at edge N+WIDTH+2.
  - For WIDTH=32, output1 is correct no later than 36 clock cycles after any input change.
- Input change mid-computation:
  - In RUN or DONE, if input1/input2 differ from M_reg/Q_reg, abandon the computation, go to LOAD next cycle, and do not write output1.
  - output1 keeps its last completed result until the new computation finishes.
- Stable inputs: no recomputation; output1 is constant and not glitched.
- Arithmetic: the result is an exact 64-bit signed product for all inputs, including -2^31 * -2^31 = +2^62 and 0*x = 0.
- output1 is driven only from a register, never combinationally from the inputs.

Decomposition:
- Package shift_mult_pkg holds:
  - WIDTH default constant.
  - State typedef enum {LOAD, RUN, DONE, HOLD}.
  - Counter width constant $clog2(WIDTH+1).
- One sub-module, booth_shift_core: owns M_reg, the P register, the counter and the Booth add/sub plus arithmetic shift.
  - Inputs: start, operands.
  - Outputs: done pulse, product.
- shift_integration owns the change-detect FSM and the output1 register.

Test Plan:
- Reset: assert rst_n=0 mid-run -> output1=0 immediately. Release with input1=5, input2=5 -> output1=25 within 36 cycles.
- Sign mix, each applied and held for 50 cycles:
  - 5 * -5 -> 0xFFFFFFFFFFFFFFE7.
  - -5 * -5 -> 0x19.
  - -5 * 5 -> 0xFFFFFFFFFFFFFFE7.
  - -12 * 6 -> 0xFFFFFFFFFFFFFFB8 (-72).
- Identity and zero:
  - 0 * -5 -> 0.
  - 1 * -5 -> 0xFFFFFFFFFFFFFFFB.
  - 8 * 6 -> 0x30.
- Extremes:
  - 0x80000000 * 0x80000000 -> 0x4000000000000000.
  - 0x7FFFFFFF * 0x80000000 -> 0xC000000080000000.
  - 0xFFFFFFFF * 0xFFFFFFFF -> 1.
- Mid-run change: apply 3*3, change to 7*-2 after 10 cycles.
  - output1 never shows 9 from the abandoned run, and keeps its previous value until the new result.
  - output1 = -14 (0xFFFFFFFFFFFFFFF2) within 36 cycles of the change.
- Stability: hold 5*5 for 200 cycles -> output1 stays 25 on every cycle once settled; no state return to LOAD.
